imem_loader: RTL and testbench

- Write-side companion to the instruction memory: loads a program image from a byte stream (UART RX or debug bridge) into the instruction memory write port.
- Holds the core in reset while loading and releases it when the image is complete.
- Sits between the byte receiver and the instruction memory.
- The memory's existing read path (PC to instruction) is unchanged.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_word_assembler.sv | 52 +++++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared constants for the instruction-memory loader and the instruction memory.
//   DEPTH_DEFAULT / ADDR_W_DEFAULT : default memory geometry (32 words, 5-bit index)
//   BYTES_PER_WORD                 : bytes per instruction word
//   state_t / ST_*                 : loader FSM encoding (plain constants so the
//                                    encoding is visible in legacy netlists)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int DEPTH_DEFAULT  = 32;
    localparam int ADDR_W_DEFAULT = 5;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CHK  = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

endpackage

// File: rtl/imem_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler
// Packs a little-endian byte stream into 32-bit words.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart at lane 0 (new load session)
//   in_valid    : in_data is consumed this cycle
//   in_data     : byte to insert at the current lane
//   lane        : lane the next byte will land in (0 = bits [7:0])
//   word_valid  : one-cycle pulse, the cycle after the fourth byte
//   word        : assembled word, complete while word_valid is high
// -----------------------------------------------------------------------------
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic [LANE_W-1:0] lane,
    output logic              word_valid,
    output logic [31:0]       word
);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= '0;
            end else if (in_valid) begin
                // Insert in place; a byte accepted during the word_valid cycle
                // only overwrites lane 0 after that cycle has ended.
                word[lane*8 +: 8] <= in_data;
                if (lane == LANE_LAST) begin
                    lane       <= '0;
                    word_valid <= 1'b1;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program image from a byte stream into the instruction-memory write
// port and holds the core while loading. Image format: one header byte N
// (1..DEPTH words), then 4*N data bytes, little-endian per word.
// Optional macro IMEM_LOADER_CHECKSUM_EN: one trailing byte that must equal the
// XOR of all data bytes.
//   clk, reset    : clock, synchronous active-high reset
//   start         : pulse; begins a session from IDLE, DONE or ERR
//   rx_data/valid : incoming byte stream; rx_ready accepts it
//   mem_we/addr/wdata : instruction-memory write port, one pulse per word
//   core_hold     : core reset/PC hold while an image is being loaded
//   done / error  : session ended successfully / aborted (levels)
//   words_loaded  : words written in the current session
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

    state_t            state, next_state;
    logic [ADDR_W:0]   n_words;
    logic [LANE_W-1:0] lane;
    logic              accept, start_ok, hdr_bad, word_end, last_word;

    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign hdr_bad   = (rx_data == 8'd0) || (int'(rx_data) > DEPTH);
    assign word_end  = accept && (state == ST_DATA) && (lane == LANE_LAST);
    assign last_word = (words_loaded + 1'b1) == n_words;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;

    always_ff @(posedge clk) begin
        if (reset) begin
            xsum <= '0;
        end else if (start_ok) begin
            xsum <= '0;
        end else if (accept && state == ST_DATA) begin
            xsum <= xsum ^ rx_data;
        end
    end
`endif

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_HDR;
            ST_HDR:  if (accept) next_state = hdr_bad ? ST_ERR : ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_DATA: if (word_end && last_word) next_state = ST_CHK;
            ST_CHK:  if (accept) next_state = (rx_data == xsum) ? ST_DONE : ST_ERR;
`else
            ST_DATA: if (word_end && last_word) next_state = ST_DONE;
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rx_ready     <= 1'b0;
            core_hold    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            n_words      <= '0;
            words_loaded <= '0;
            mem_addr     <= '0;
        end else begin
            state    <= next_state;
            rx_ready <= (next_state == ST_HDR) || (next_state == ST_DATA) ||
                        (next_state == ST_CHK);
            // Leaving DATA for DONE happens on the last byte, so the final write
            // pulse is still ahead: keep the core held for that one cycle.
            core_hold <= (next_state == ST_HDR) || (next_state == ST_DATA) ||
                         (next_state == ST_CHK) || (next_state == ST_ERR) ||
                         (next_state == ST_DONE && state == ST_DATA);
            done  <= (next_state == ST_DONE);
            error <= (next_state == ST_ERR);

            if (accept && state == ST_HDR) begin
                n_words <= rx_data[ADDR_W:0];
            end

            // Count and index update together with the write pulse rising.
            if (start_ok) begin
                words_loaded <= '0;
            end else if (word_end) begin
                words_loaded <= words_loaded + 1'b1;
                mem_addr     <= words_loaded[ADDR_W-1:0];
            end
        end
    end

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .in_valid   (accept && state == ST_DATA),
        .in_data    (rx_data),
        .lane       (lane),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader (DEPTH=32). Define IMEM_LOADER_CHECKSUM_EN for
// both bench and RTL to exercise the checksum build.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    imem_loader #(.DEPTH(32), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write log and timing monitor, sampled on the falling edge.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          last_we_cyc = 0;
    int          hold_fall_cyc = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] wr_data [64];
    logic [31:0] wr_addr [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = 32'(mem_addr);
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt      = wr_cnt + 1;
            last_we_cyc = cyc;
        end
        if (prev_hold && !core_hold) hold_fall_cyc = cyc;
        prev_hold = core_hold;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] xsum;

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        if (gap) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        tick();
    endtask

    task automatic send_hdr(input logic [7:0] n);
        xsum = 8'h00;
        send_byte(n, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            xsum = xsum ^ w[i*8 +: 8];
            send_byte(w[i*8 +: 8], gap);
        end
    endtask

    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum, 1'b0);
`endif
        rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [31:0] img_word(input int i);
        return {8'(i), 8'hA5, 8'(255 - i), 8'(i * 3 + 1)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready),     32'd0);
        check({tag, "_mem_we"},    32'(mem_we),       32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),     32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
        check({tag, "_core_hold"}, 32'(core_hold),    32'd0);
        check({tag, "_done"},      32'(done),         32'd0);
        check({tag, "_error"},     32'(error),        32'd0);
        check({tag, "_words"},     32'(words_loaded), 32'd0);
    endtask

    int base;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // ---- two-word image, rx_valid held high
        base = wr_cnt;
        pulse_start();
        check("t1_hold_on_start", 32'(core_hold), 32'd1);
        check("t1_ready_on_start", 32'(rx_ready), 32'd1);
        send_hdr(8'h02);
        send_word(32'h0030_0093, 1'b0);
        send_word(32'h0050_0113, 1'b0);
        finish_image();
        check("t1_wr_count", 32'(wr_cnt - base), 32'd2);
        check("t1_addr0", wr_addr[base],     32'd0);
        check("t1_data0", wr_data[base],     32'h0030_0093);
        check("t1_addr1", wr_addr[base + 1], 32'd1);
        check("t1_data1", wr_data[base + 1], 32'h0050_0113);
        check("t1_done",  32'(done),         32'd1);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_hold",  32'(core_hold),    32'd0);
        check("t1_hold_fall_delay", 32'(hold_fall_cyc - last_we_cyc), 32'd1);
        check("t1_ready_done", 32'(rx_ready), 32'd0);

        // ---- bad headers: 0 and DEPTH+1
        base = wr_cnt;
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_words_cleared", 32'(words_loaded), 32'd0);
        send_hdr(8'h00);
        rx_valid = 1'b0;
        repeat (2) tick();
        check("t2_err0", 32'(error), 32'd1);
        check("t2_hold0", 32'(core_hold), 32'd1);
        check("t2_ready0", 32'(rx_ready), 32'd0);
        pulse_start();
        check("t2_err_cleared", 32'(error), 32'd0);
        send_hdr(8'h21);
        rx_valid = 1'b0;
        repeat (2) tick();
        check("t2_err21", 32'(error), 32'd1);
        check("t2_hold21", 32'(core_hold), 32'd1);
        check("t2_ready21", 32'(rx_ready), 32'd0);
        check("t2_no_writes", 32'(wr_cnt - base), 32'd0);

        // ---- full 32-word image, rx_valid toggling
        base = wr_cnt;
        pulse_start();
        send_hdr(8'd32);
        for (int i = 0; i < 32; i++) send_word(img_word(i), 1'b1);
        finish_image();
        check("t3_wr_count", 32'(wr_cnt - base), 32'd32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t3_addr%0d", i), wr_addr[base + i], 32'(i));
            check($sformatf("t3_data%0d", i), wr_data[base + i], img_word(i));
        end
        check("t3_words", 32'(words_loaded), 32'd32);
        check("t3_done", 32'(done), 32'd1);

        // ---- reset after 6 data bytes
        base = wr_cnt;
        pulse_start();
        send_hdr(8'h02);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check_all_zero("t4");
        reset = 1'b0;
        repeat (3) tick();
        check("t4_wr_count", 32'(wr_cnt - base), 32'd1);
        check("t4_data0", wr_data[base], 32'h4433_2211);
        check("t4_idle_hold", 32'(core_hold), 32'd0);

        // ---- start ignored in DATA, honoured in DONE
        base = wr_cnt;
        pulse_start();
        send_hdr(8'h01);
        send_byte(8'hAA, 1'b0);
        xsum = xsum ^ 8'hAA;
        send_byte(8'hBB, 1'b0);
        xsum = xsum ^ 8'hBB;
        rx_valid = 1'b0;
        pulse_start();
        check("t5_ready_kept", 32'(rx_ready), 32'd1);
        check("t5_words_kept", 32'(words_loaded), 32'd0);
        check("t5_err_kept", 32'(error), 32'd0);
        send_byte(8'hCC, 1'b0);
        xsum = xsum ^ 8'hCC;
        send_byte(8'hDD, 1'b0);
        xsum = xsum ^ 8'hDD;
        finish_image();
        check("t5_wr_count", 32'(wr_cnt - base), 32'd1);
        check("t5_data", wr_data[base], 32'hDDCC_BBAA);
        check("t5_done", 32'(done), 32'd1);
        pulse_start();
        check("t5_restart_done", 32'(done), 32'd0);
        check("t5_restart_hold", 32'(core_hold), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- checksum match and mismatch
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_byte(8'h13, 1'b0);
        rx_valid = 1'b0;
        repeat (2) tick();
        check("t6_sum_ok_done", 32'(done), 32'd1);
        check("t6_sum_ok_err", 32'(error), 32'd0);
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_byte(8'h12, 1'b0);
        rx_valid = 1'b0;
        repeat (2) tick();
        check("t6_sum_bad_err", 32'(error), 32'd1);
        check("t6_sum_bad_hold", 32'(core_hold), 32'd1);
        check("t6_sum_bad_done", 32'(done), 32'd0);
        check("t6_sum_bad_written", wr_data[base], 32'h0000_0013);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
